seq_divider_32b: RTL and testbench

Sequential unsigned restoring divider for the ALU, the inverse companion to the sequential multiplier. It produces one quotient bit per clock using a trial subtraction, and may reuse the existing sub_32b subtractor. A start/busy/done handshake matches the multiplier so the ALU control FSM can drive both blocks the same way. Results stay registered until the next accepted start.

---
 rtl/seq_divider_32b.sv | 109 ++++++++++
 tb/tb_seq_divider_32b.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_32b.sv
// Sequential unsigned restoring divider: one quotient bit per clock via trial subtraction.
// Shares the start/busy/done handshake of the sequential multiplier so one ALU FSM drives both.
module seq_divider_32b #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge in IDLE (operands captured there);
  // busy stays high from the cycle after acceptance through the one-cycle done pulse.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   r_shift;
  logic             borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign dbg_state = state_q;

  // The partial remainder is always below the divisor, so WIDTH bits hold it between
  // steps; only the shifted trial value needs the extra bit.
  assign r_shift = {r_q, q_q[WIDTH-1]};
  assign borrow  = (r_shift < {1'b0, div_q});
  assign r_next  = borrow ? r_shift[WIDTH-1:0] : (r_shift[WIDTH-1:0] - div_q);
  assign q_next  = {q_q[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (divisor == '0) ? S_DONE : S_DIVIDE;
      end
      S_DIVIDE: begin
        busy = 1'b1;
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q         <= '0;
      q_q         <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_q       <= divisor;
      div_by_zero <= (divisor == '0);
      r_q         <= '0;
      q_q         <= dividend;
      cnt_q       <= '0;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state_q == S_DIVIDE) begin
      r_q   <= r_next;
      q_q   <= q_next;
      cnt_q <= cnt_q + 1'b1;
      if (last_step) begin
        quotient  <= q_next;
        remainder <= r_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_32b.sv
// Scoreboard bench for seq_divider_32b: expected results queued at start, checked on done.
module tb_seq_divider_32b;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  // scoreboard entry: {div_by_zero, quotient, remainder}
  logic [2*W:0] exp_q[$];
  int           lat_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           done_cnt = 0;
  int           lat_cnt = 0;
  int           busy_cnt = 0;

  seq_divider_32b #(.WIDTH(W), .CNT_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) lat_cnt++;

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv);
    if (dv == '0) return {1'b1, {W{1'b1}}, dd};
    return {1'b0, dd / dv, dd % dv};
  endfunction

  // drivers
  task automatic do_div(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit push);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    if (push) begin
      exp_q.push_back(model(dd, dv));
      lat_q.push_back((dv == '0) ? 0 : W);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    lat_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", {busy, exp_q.size() != 0}, 0);
  endtask

  // monitor + scoreboard compare
  always @(negedge clk) begin
    logic [2*W:0] e;
    int           l;
    if (!reset) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          l = lat_q.pop_front();
          check("quotient", quotient, e[2*W-1:W]);
          check("remainder", remainder, e[W-1:0]);
          check("div_by_zero", div_by_zero, e[2*W]);
          if (l >= 0) begin
            check("latency", lat_cnt, l);
            check("busy_cycles", busy_cnt, l + 1);
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    logic [W-1:0] dd, dv;
    reset = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    reset = 1'b0;

    // basic, full-scale, small, divide-by-zero
    do_div(100, 7, 1);                   wait_idle();
    do_div(32'hFFFF_FFFF, 1, 1);         wait_idle();
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); wait_idle();
    do_div(5, 9, 1);                     wait_idle();
    do_div(0, 13, 1);                    wait_idle();
    do_div(1234, 0, 1);                  wait_idle();
    do_div(229, 114, 1);                 wait_idle();

    // start pulse while busy must be ignored
    base = done_cnt;
    do_div(1000, 3, 1);
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; dividend = 50; divisor = 5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    check("ignored_start_dones", done_cnt - base, 1);

    // held start runs back-to-back operations
    base = done_cnt;
    @(negedge clk);
    start = 1'b1; dividend = 20; divisor = 3;
    exp_q.push_back(model(20, 3)); lat_q.push_back(-1);
    exp_q.push_back(model(20, 3)); lat_q.push_back(-1);
    n = 0;
    while (done_cnt < base + 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    wait_idle();
    check("held_start_dones", done_cnt - base, 2);

    // reset mid-operation clears outputs without a clock and suppresses done
    do_div(7, 0, 1); wait_idle();
    base = done_cnt;
    do_div(500, 4, 0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    check("mid_rst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (40) @(posedge clk);
    check("mid_rst_no_done", done_cnt - base, 0);
    do_div(500, 4, 1); wait_idle();

    // random operands
    for (int i = 0; i < 8; i++) begin
      dd = $urandom;
      dv = (i % 3 == 0) ? W'($urandom) : W'($urandom_range(1, 1000));
      if (dv == '0) dv = 1;
      do_div(dd, dv, 1);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
